// File: rtl/upower_pkg.sv
// Shared definitions for the UPOWER fetch/control block: opcode and XO
// constants, ALU and write-register select codes, FSM states and decode record.
package upower_pkg;

    localparam logic [5:0] OP_ADDI = 6'd14;
    localparam logic [5:0] OP_LWZ  = 6'd32;
    localparam logic [5:0] OP_STW  = 6'd36;
    localparam logic [5:0] OP_ORI  = 6'd24;
    localparam logic [5:0] OP_ANDI = 6'd28;
    localparam logic [5:0] OP_X    = 6'd31;

    localparam logic [9:0] XO_ADD  = 10'd266;
    localparam logic [9:0] XO_SUBF = 10'd40;
    localparam logic [9:0] XO_AND  = 10'd28;
    localparam logic [9:0] XO_OR   = 10'd444;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_e;

    // Write-register field: RA = IR[20:16], RB = IR[15:11], RT = IR[25:21].
    typedef enum logic [1:0] {
        RD_RA = 2'b00,
        RD_RB = 2'b01,
        RD_RT = 2'b10
    } regdst_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        IC_ALU,
        IC_LOAD,
        IC_STORE
    } iclass_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        regdst_e reg_dst;
        logic    xo;
        logic    mem_to_reg;
        iclass_e iclass;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        alu_op:     ALU_AND,
        alu_src:    1'b0,
        reg_dst:    RD_RA,
        xo:         1'b0,
        mem_to_reg: 1'b0,
        iclass:     IC_ALU
    };

    function automatic ctrl_t mk_ctrl(input alu_op_e op, input logic src, input regdst_e rd,
                                      input logic xo, input logic mtr, input iclass_e ic);
        ctrl_t c;
        c.alu_op     = op;
        c.alu_src    = src;
        c.reg_dst    = rd;
        c.xo         = xo;
        c.mem_to_reg = mtr;
        c.iclass     = ic;
        return c;
    endfunction

endpackage

// File: rtl/upower_fetch_control_if.sv
// Instruction-memory fetch port: request/address out, acknowledge/data back.
interface upower_fetch_control_if #(
    parameter int N = 32
) ();

    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/upower_decoder.sv
// Purely combinational instruction decoder: IR in, static datapath controls
// plus a valid flag out (valid=0 means the opcode/XO pair is unsupported).
module upower_decoder
    import upower_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl,
    output logic        valid
);

    logic [5:0] opcode;
    logic [9:0] xo_field;
    logic       unused_fields;

    assign opcode        = ir[31:26];
    assign xo_field      = ir[10:1];
    assign unused_fields = ^{ir[25:11], ir[0]};

    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
    always_comb begin
        ctrl  = CTRL_RESET;
        valid = 1'b1;
        case (opcode)
            OP_ADDI: ctrl = mk_ctrl(ALU_ADD, 1'b1, RD_RT, 1'b1, 1'b0, IC_ALU);
            OP_LWZ:  ctrl = mk_ctrl(ALU_ADD, 1'b1, RD_RT, 1'b0, 1'b1, IC_LOAD);
            OP_STW:  ctrl = mk_ctrl(ALU_ADD, 1'b1, RD_RA, 1'b1, 1'b0, IC_STORE);
            OP_ORI:  ctrl = mk_ctrl(ALU_OR,  1'b1, RD_RA, 1'b0, 1'b0, IC_ALU);
            OP_ANDI: ctrl = mk_ctrl(ALU_AND, 1'b1, RD_RA, 1'b0, 1'b0, IC_ALU);
            OP_X: begin
                case (xo_field)
                    XO_ADD:  ctrl = mk_ctrl(ALU_ADD, 1'b0, RD_RT, 1'b1, 1'b0, IC_ALU);
                    XO_SUBF: ctrl = mk_ctrl(ALU_SUB, 1'b0, RD_RT, 1'b1, 1'b0, IC_ALU);
                    XO_AND:  ctrl = mk_ctrl(ALU_AND, 1'b0, RD_RA, 1'b0, 1'b0, IC_ALU);
                    XO_OR:   ctrl = mk_ctrl(ALU_OR,  1'b0, RD_RA, 1'b0, 1'b0, IC_ALU);
                    default: valid = 1'b0;
                endcase
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/upower_fetch_control.sv
// Multi-cycle fetch/control unit: fetches into IR, decodes, sequences
// EXEC/MEM/WB strobes, advances PC and counts retired instructions.
module upower_fetch_control
    import upower_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    upower_fetch_control_if.master        imem,
    output logic [N-1:0]                  instruction,
    output logic                          RegWrite,
    output logic                          MemRead,
    output logic                          MemWrite,
    output logic                          MemtoReg,
    output logic                          ALUSrc,
    output logic                          XO,
    output logic [1:0]                    RegDst,
    output logic [3:0]                    ALU_OP,
    output logic                          illegal,
    output logic [31:0]                   retired
);

    state_e       state;
    state_e       state_nxt;
    logic [N-1:0] pc;
    logic [N-1:0] ir;
    logic [31:0]  retired_q;
    logic         illegal_q;
    ctrl_t        ctrl_q;
    ctrl_t        dec_ctrl;
    logic         dec_valid;

    logic         req;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         retire;

    upower_decoder u_decoder (
        .ir    (ir[31:0]),
        .ctrl  (dec_ctrl),
        .valid (dec_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        retire    = 1'b0;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = dec_valid ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                state_nxt = (ctrl_q.iclass == IC_ALU) ? S_WB : S_MEM;
            end
            S_MEM: begin
                mem_read  = (ctrl_q.iclass == IC_LOAD);
                mem_write = (ctrl_q.iclass == IC_STORE);
                if (ctrl_q.iclass == IC_STORE) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                mem_read  = (ctrl_q.iclass == IC_LOAD);
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // IR only loads in FETCH, so a stray acknowledge elsewhere has no effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= RESET_PC;
            ir        <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            ctrl_q    <= CTRL_RESET;
        end else begin
            if (state == S_FETCH && imem.imem_ack) begin
                ir <= imem.imem_rdata;
            end
            if (state == S_DECODE) begin
                if (dec_valid) begin
                    ctrl_q <= dec_ctrl;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
            if (retire) begin
                pc        <= pc + N'(4);
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // Strobes are masked by reset so a reset cycle never emits a write.
    assign imem.imem_req  = req & rst;
    assign imem.imem_addr = pc;
    assign RegWrite       = reg_write & rst;
    assign MemRead        = mem_read & rst;
    assign MemWrite       = mem_write & rst;

    assign instruction    = ir;
    assign MemtoReg       = ctrl_q.mem_to_reg;
    assign ALUSrc         = ctrl_q.alu_src;
    assign XO             = ctrl_q.xo;
    assign RegDst         = ctrl_q.reg_dst;
    assign ALU_OP         = ctrl_q.alu_op;
    assign illegal        = illegal_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_upower_fetch_control.sv
// Self-checking bench for upower_fetch_control: directed vector table, trap and
// mid-instruction reset sequences, then random programs against a reference model.
module tb_upower_fetch_control;

    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;
    localparam int          NV        = 10;
    localparam int          NRAND     = 300;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_BAD} kind_e;

    typedef struct {
        logic [31:0] word;
        int          delay;
        kind_e       kind;
        logic [3:0]  alu;
        logic        src;
        logic [1:0]  rd;
        logic        xo;
        logic        mtr;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic [9:0] xo_f;
        kind_e      kind;
        logic [3:0] alu;
        logic       src;
        logic [1:0] rd;
        logic       xo;
        logic       mtr;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    upower_fetch_control_if #(.N(32)) imem ();
    upower_fetch_control_if #(.N(32)) imem_w ();
    assign imem_w.imem_ack   = imem.imem_ack;
    assign imem_w.imem_rdata = imem.imem_rdata;

    logic [31:0] instruction, retired;
    logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, XO, illegal;
    logic [1:0]  RegDst;
    logic [3:0]  ALU_OP;

    logic [31:0] w_instr_unused, w_retired_unused;
    logic        w_rw_unused, w_mr_unused, w_mw_unused, w_mtr_unused;
    logic        w_src_unused, w_xo_unused, w_ill_unused;
    logic [1:0]  w_rd_unused;
    logic [3:0]  w_alu_unused;

    upower_fetch_control #(.N(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem(imem),
        .instruction(instruction), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .XO(XO),
        .RegDst(RegDst), .ALU_OP(ALU_OP), .illegal(illegal), .retired(retired)
    );

    // Second instance starts near the top of the address space to exercise PC wrap.
    upower_fetch_control #(.N(32), .RESET_PC(WRAP_BASE)) dut_w (
        .clk(clk), .rst(rst), .imem(imem_w),
        .instruction(w_instr_unused), .RegWrite(w_rw_unused), .MemRead(w_mr_unused),
        .MemWrite(w_mw_unused), .MemtoReg(w_mtr_unused), .ALUSrc(w_src_unused),
        .XO(w_xo_unused), .RegDst(w_rd_unused), .ALU_OP(w_alu_unused),
        .illegal(w_ill_unused), .retired(w_retired_unused)
    );

    logic [2:0] strobes;
    logic [8:0] ctrl_act;
    assign strobes  = {RegWrite, MemRead, MemWrite};
    assign ctrl_act = {ALU_OP, ALUSrc, RegDst, XO, MemtoReg};

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_retired;
    logic [8:0]  prev_ctrl;
    logic [8:0]  prev_mask;
    op_t         optab [9];
    vec_t        vec   [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference decode: look the word up in the instruction-set table.
    function automatic vec_t ref_decode(input logic [31:0] w, input int delay);
        vec_t r;
        r.word = w;
        r.delay = delay;
        r.kind = K_BAD;
        r.alu = '0;
        r.src = 1'b0;
        r.rd = '0;
        r.xo = 1'b0;
        r.mtr = 1'b0;
        foreach (optab[i]) begin
            if (optab[i].op == w[31:26] && (optab[i].op != 6'd31 || optab[i].xo_f == w[10:1])) begin
                r.kind = optab[i].kind;
                r.alu  = optab[i].alu;
                r.src  = optab[i].src;
                r.rd   = optab[i].rd;
                r.xo   = optab[i].xo;
                r.mtr  = optab[i].mtr;
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        imem.imem_ack = 1'b0;
        step();
        check("rst_strobes", strobes, 3'b000);
        check("rst_ctrl", ctrl_act, 9'h000);
        check("rst_illegal", illegal, 1'b0);
        check("rst_retired", retired, 32'h0);
        check("rst_ir", instruction, 32'h0);
        check("rst_pc", imem.imem_addr, 32'h0);
        check("rst_pc_w", imem_w.imem_addr, WRAP_BASE);
        step();
        rst = 1'b1;
        #1;
        exp_pc = 32'h0;
        exp_retired = 32'h0;
        prev_ctrl = 9'h000;
        prev_mask = 9'h1FF;
    endtask

    // One complete instruction: fetch (with stall), then per-cycle strobe and control checks.
    task automatic run_instr(input vec_t v);
        logic [8:0]  ec, em;
        logic [31:0] wexp;
        logic        rw, mr, mw;
        int          n;
        ec = {v.alu, v.src, v.rd, v.xo, v.mtr};
        em = (v.kind == K_STORE) ? 9'h1F3 : 9'h1FF;
        wexp = exp_pc + WRAP_BASE;
        for (int d = 0; d <= v.delay; d++) begin
            check("fetch_req", imem.imem_req, 1'b1);
            check("fetch_addr", imem.imem_addr, exp_pc);
            check("wrap_addr", imem_w.imem_addr, wexp);
            check("fetch_strobes", strobes, 3'b000);
            check("retired", retired, exp_retired);
            imem.imem_ack   = (d == v.delay);
            imem.imem_rdata = (d == v.delay) ? v.word : $urandom;
            step();
        end
        n = (v.kind == K_LOAD) ? 4 : 3;
        for (int k = 1; k <= n; k++) begin
            rw = (k == n) && (v.kind != K_STORE);
            mr = (v.kind == K_LOAD) && (k >= 3);
            mw = (v.kind == K_STORE) && (k == 3);
            check("strobes", strobes, {rw, mr, mw});
            check("ir", instruction, v.word);
            if (k == 1) check("ctrl_hold", ctrl_act & prev_mask, prev_ctrl & prev_mask);
            else        check("ctrl", ctrl_act & em, ec & em);
            check("no_illegal", illegal, 1'b0);
            imem.imem_ack   = 1'($urandom_range(0, 1));
            imem.imem_rdata = $urandom;
            step();
        end
        imem.imem_ack = 1'b0;
        exp_pc = exp_pc + 32'd4;
        exp_retired = exp_retired + 32'd1;
        prev_ctrl = ec;
        prev_mask = em;
    endtask

    task automatic trap_seq(input logic [31:0] w);
        check("trap_fetch_addr", imem.imem_addr, exp_pc);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = w;
        step();
        check("decode_illegal", illegal, 1'b0);
        check("decode_strobes", strobes, 3'b000);
        imem.imem_ack   = 1'($urandom_range(0, 1));
        imem.imem_rdata = $urandom;
        step();
        for (int c = 0; c < 6; c++) begin
            check("trap_illegal", illegal, 1'b1);
            check("trap_req", imem.imem_req, 1'b0);
            check("trap_strobes", strobes, 3'b000);
            check("trap_pc", imem.imem_addr, exp_pc);
            check("trap_ir", instruction, w);
            check("trap_retired", retired, exp_retired);
            imem.imem_ack   = 1'($urandom_range(0, 1));
            imem.imem_rdata = $urandom;
            step();
        end
        imem.imem_ack = 1'b0;
    endtask

    // Reset asserted during the MEM cycle of a load or store issued right after reset.
    task automatic reset_in_mem(input logic [31:0] w, input logic is_store);
        check("rm_fetch_addr", imem.imem_addr, exp_pc);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = w;
        step();
        imem.imem_ack = 1'b0;
        step();
        step();
        check("rm_mem_strobe", strobes, is_store ? 3'b001 : 3'b010);
        rst = 1'b0;
        #1;
        check("rm_drop", {RegWrite, MemWrite}, 2'b00);
        step();
        check("rm_regwrite", RegWrite, 1'b0);
        check("rm_pc", imem.imem_addr, 32'h0);
        check("rm_retired", retired, 32'h0);
        step();
        rst = 1'b1;
        #1;
        check("rm_refetch_req", imem.imem_req, 1'b1);
        exp_pc = 32'h0;
        exp_retired = 32'h0;
        prev_ctrl = 9'h000;
        prev_mask = 9'h1FF;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit exceeded, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t rv;
        logic [31:0] w;
        int sel;
        rst = 1'b0;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = 32'h0;

        optab[0] = '{6'd14, 10'd0,   K_ALU,   4'b0010, 1'b1, 2'b10, 1'b1, 1'b0};
        optab[1] = '{6'd32, 10'd0,   K_LOAD,  4'b0010, 1'b1, 2'b10, 1'b0, 1'b1};
        optab[2] = '{6'd36, 10'd0,   K_STORE, 4'b0010, 1'b1, 2'b00, 1'b1, 1'b0};
        optab[3] = '{6'd24, 10'd0,   K_ALU,   4'b0001, 1'b1, 2'b00, 1'b0, 1'b0};
        optab[4] = '{6'd28, 10'd0,   K_ALU,   4'b0000, 1'b1, 2'b00, 1'b0, 1'b0};
        optab[5] = '{6'd31, 10'd266, K_ALU,   4'b0010, 1'b0, 2'b10, 1'b1, 1'b0};
        optab[6] = '{6'd31, 10'd40,  K_ALU,   4'b0110, 1'b0, 2'b10, 1'b1, 1'b0};
        optab[7] = '{6'd31, 10'd28,  K_ALU,   4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
        optab[8] = '{6'd31, 10'd444, K_ALU,   4'b0001, 1'b0, 2'b00, 1'b0, 1'b0};

        vec[0] = '{32'h3A20_0014, 0, K_ALU,   4'b0010, 1'b1, 2'b10, 1'b1, 1'b0};
        vec[1] = '{32'h8022_0001, 0, K_LOAD,  4'b0010, 1'b1, 2'b10, 1'b0, 1'b1};
        vec[2] = '{32'h9022_0002, 0, K_STORE, 4'b0010, 1'b1, 2'b00, 1'b1, 1'b0};
        vec[3] = '{32'h6043_00FF, 3, K_ALU,   4'b0001, 1'b1, 2'b00, 1'b0, 1'b0};
        vec[4] = '{32'h7043_1234, 1, K_ALU,   4'b0000, 1'b1, 2'b00, 1'b0, 1'b0};
        vec[5] = '{32'h7C22_1A14, 2, K_ALU,   4'b0010, 1'b0, 2'b10, 1'b1, 1'b0};
        vec[6] = '{32'h7C22_1850, 0, K_ALU,   4'b0110, 1'b0, 2'b10, 1'b1, 1'b0};
        vec[7] = '{32'h7C22_1838, 1, K_ALU,   4'b0000, 1'b0, 2'b00, 1'b0, 1'b0};
        vec[8] = '{32'h7C22_1B78, 0, K_ALU,   4'b0001, 1'b0, 2'b00, 1'b0, 1'b0};
        vec[9] = '{32'h8022_0001, 2, K_LOAD,  4'b0010, 1'b1, 2'b10, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            run_instr(vec[i]);
            if (i == 1) check("pc_wrap_to_zero", imem_w.imem_addr, 32'h0);
        end

        trap_seq(32'h0400_0000);
        do_reset();
        run_instr(vec[0]);
        trap_seq(32'h7C00_0000);
        do_reset();

        reset_in_mem(32'h8022_0001, 1'b0);
        reset_in_mem(32'h9022_0002, 1'b1);

        for (int r = 0; r < NRAND; r++) begin
            sel = $urandom_range(0, 8);
            w = $urandom;
            w[31:26] = optab[sel].op;
            if (optab[sel].op == 6'd31) w[10:1] = optab[sel].xo_f;
            rv = ref_decode(w, $urandom_range(0, 3));
            run_instr(rv);
        end
        check("final_retired", retired, exp_retired);
        check("final_addr", imem.imem_addr, exp_pc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
